// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps ab=00..11 into and1/or1/not1 and grades each vector (GATE_SWEEP_LOOP_EN: repeat sweeps)
module gate_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [7:0] cnt;

  logic load_vec;
  logic check_en;
  logic settle_en;
  logic sweep_clr;
  logic done_set;
  logic mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == 8'd0) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (idx == 2'd3) ? S_DONE : S_DRIVE;
`ifdef GATE_SWEEP_LOOP_EN
      S_DONE:   state_nxt = S_DRIVE;
`else
      S_DONE:   state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
    load_vec  = (state == S_DRIVE);
    settle_en = (state == S_SETTLE);
    check_en  = (state == S_CHECK);
    done_set  = (state == S_DONE);
`ifdef GATE_SWEEP_LOOP_EN
    sweep_clr = ((state == S_IDLE) && start) || (state == S_DONE);
`else
    sweep_clr = (state == S_IDLE) && start;
`endif
  end

  // a_out/b_out still hold the vector under test while in CHECK
  assign mismatch = (and_in != (a_out & b_out)) ||
                    (or_in  != (a_out | b_out)) ||
                    (not_in != ~a_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 2'd0;
      cnt   <= 8'd0;
      a_out <= 1'b0;
      b_out <= 1'b0;
    end else begin
      if (sweep_clr) begin
        idx <= 2'd0;
      end else if (check_en && (idx != 2'd3)) begin
        idx <= idx + 2'd1;
      end

      if (load_vec) begin
        cnt   <= HOLD_LAST;
        a_out <= idx[1];
        b_out <= idx[0];
      end else if (settle_en && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      done <= done_set;

      if (sweep_clr) begin
        err_count <= 3'd0;
        fail_vec  <= 4'd0;
      end else if (check_en && mismatch) begin
        fail_vec[idx] <= 1'b1;
        if (err_count != 3'd4) begin
          err_count <= err_count + 3'd1;
        end
      end

      // in loop mode DONE also restarts, so the verdict must win over the clear
      if (done_set) begin
        pass <= (err_count == 3'd0);
      end else if (sweep_clr) begin
        pass <= 1'b0;
      end
    end
  end

endmodule
